// File: rtl/dm_pkg.sv
// Shared definitions for the byte-lane data memory: size codes, FSM states
// and lane helpers used by dm_bytelane_mem and dm_load_extract.
package dm_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic [3:0] lane_strobe(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] s;
        case (size)
            SZ_B:    s = 4'b0001 << lane;
            SZ_H:    s = 4'b0011 << lane;
            SZ_W:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic align_err(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic e;
        case (size)
            SZ_B:    e = 1'b0;
            SZ_H:    e = lane[0];
            SZ_W:    e = |lane;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Right-justified store data copied into every lane it could target.
    function automatic logic [31:0] replicate(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] r;
        case (size)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Even parity bit per byte: byte plus its bit has an even number of ones.
    function automatic logic [3:0] byte_par(input logic [31:0] w);
        return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
    endfunction

endpackage

// File: rtl/dm_load_extract.sv
// Combinational load extraction: picks the addressed byte/half from the
// raw word and sign- or zero-extends it. Ports: raw, lane, size, sgn -> result.
module dm_load_extract
    import dm_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = raw[{lane, 3'b000} +: 8];
        h = lane[1] ? raw[31:16] : raw[15:0];
        case (size)
            SZ_B:    result = {{24{sgn & b[7]}}, b};
            SZ_H:    result = {{16{sgn & h[15]}}, h};
            SZ_W:    result = raw;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_bytelane_mem.sv
// Byte-addressed data memory with lane alignment, 1-cycle registered
// response, error reporting and a zeroing sweep after reset.
// Ports: clk, reset (sync, active-high), req_* request, rsp_* response,
// clr_busy. Optional DM_PARITY_EN adds per-byte parity and dbg_flip[3:0].
module dm_bytelane_mem
    import dm_pkg::*;
#(
    parameter int DEPTH          = 2048,
    parameter int ADDR_W         = 13,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
`ifdef DM_PARITY_EN
    input  logic [3:0]        dbg_flip,
`endif
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              clr_busy
);

    localparam int IW = $clog2(DEPTH);

    state_t        st;
    logic [IW-1:0] clr_ptr;

    logic [31:0] mem [DEPTH-1:0];
`ifdef DM_PARITY_EN
    logic [3:0]  par [DEPTH-1:0];
    logic [3:0]  par_q;
`endif

    logic          accept;
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          oor;
    logic          req_err;

    logic          w_en;
    logic [IW-1:0] w_idx;
    logic [3:0]    w_strb;
    logic [31:0]   w_data;
    logic [3:0]    w_par;

    logic [31:0]   rd_q;
    logic          v_q;
    logic          err_q;
    logic          ld_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          sgn_q;
    logic [31:0]   ext;
    logic          par_err;

    assign req_ready = (st == ST_RUN);
    assign clr_busy  = (st == ST_CLEAR);

    // A request seen while reset is held must not touch the array.
    assign accept  = req_valid & req_ready & ~reset;
    assign idx     = req_addr[IW+1:2];
    assign lane    = req_addr[1:0];
    assign oor     = 32'(req_addr) >= 32'(4 * DEPTH);
    assign req_err = align_err(req_size, lane) | oor;

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_ptr <= '0;
        end else if (st == ST_CLEAR) begin
            if (clr_ptr == IW'(DEPTH - 1)) begin
                st <= ST_RUN;
            end
            clr_ptr <= clr_ptr + IW'(1);
        end
    end

    // Single write port shared by the clear sweep and stores.
    always_comb begin
        w_en   = 1'b0;
        w_idx  = idx;
        w_strb = 4'b0000;
        w_data = 32'h0;
        w_par  = 4'b0000;
        if (st == ST_CLEAR) begin
            w_en   = 1'b1;
            w_idx  = clr_ptr;
            w_strb = 4'b1111;
        end else if (accept && req_we && !req_err) begin
            w_en   = 1'b1;
            w_strb = lane_strobe(req_size, lane);
            w_data = replicate(req_size, req_wdata);
`ifdef DM_PARITY_EN
            w_par  = byte_par(w_data) ^ dbg_flip;
`else
            w_par  = byte_par(w_data);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

`ifdef DM_PARITY_EN
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    par[w_idx][i] <= w_par[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !req_we) begin
            par_q <= par[idx];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (accept && !req_we) begin
            rd_q <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= 1'b0;
            err_q  <= 1'b0;
            ld_q   <= 1'b0;
            lane_q <= 2'b00;
            size_q <= SZ_B;
            sgn_q  <= 1'b0;
        end else begin
            v_q    <= accept;
            err_q  <= accept & req_err;
            ld_q   <= accept & ~req_we;
            lane_q <= lane;
            size_q <= req_size;
            sgn_q  <= req_signed;
        end
    end

    dm_load_extract u_extract (
        .raw    (rd_q),
        .lane   (lane_q),
        .size   (size_q),
        .sgn    (sgn_q),
        .result (ext)
    );

`ifdef DM_PARITY_EN
    // Parity faults flag the response but the data is still returned.
    assign par_err = ld_q & ~err_q
                   & (|(lane_strobe(size_q, lane_q)
                        & (par_q ^ byte_par(rd_q))));
`else
    assign par_err = 1'b0;
`endif

    assign rsp_valid = v_q;
    assign rsp_err   = v_q & (err_q | par_err);
    assign rsp_rdata = (v_q && ld_q && !err_q) ? ext : 32'h0;

endmodule

// File: tb/tb_dm_bytelane_mem.sv
// Scoreboard bench for dm_bytelane_mem with a byte-array reference model.
module tb_dm_bytelane_mem;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 12;
    localparam int NB     = 4 * DEPTH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [31:0]       req_wdata = 32'h0;
`ifdef DM_PARITY_EN
    logic [3:0]        dbg_flip = 4'b0000;
`endif
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              clr_busy;

    always #5 clk = ~clk;

    dm_bytelane_mem #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
`ifdef DM_PARITY_EN
        .dbg_flip   (dbg_flip),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .clr_busy   (clr_busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [7:0]  mem_m [NB];
    bit          pbad [NB];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [32:0] act,
                         input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT responds.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=%h expected=none",
                         rsp_rdata);
            end else begin
                e = q.pop_front();
                check("rsp_latency", 33'(cyc), 33'(e.due));
                check("rsp_data", {rsp_err, rsp_rdata}, {e.err, e.rdata});
            end
        end else begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL rsp_missing actual=none expected=%h",
                         q[0].rdata);
                void'(q.pop_front());
            end
            check("idle_zero", {rsp_err, rsp_rdata}, 33'h0);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            mem_m[i] = 8'h00;
            pbad[i]  = 1'b0;
        end
    endtask

    task automatic issue(input bit we, input int addr, input logic [1:0] size,
                         input bit sgn, input logic [31:0] wd,
                         input logic [3:0] flip = 4'b0000);
        int          n;
        bit          err;
        bit          bad;
        logic [31:0] v;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = ADDR_W'(addr);
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wd;
`ifdef DM_PARITY_EN
        dbg_flip   = flip;
`endif
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready actual=0 expected=1");
            req_valid = 1'b0;
            return;
        end
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (addr % n != 0) || (addr >= NB);
        v   = 32'h0;
        bad = 1'b0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) begin
                    mem_m[addr+k] = wd[8*k +: 8];
                    pbad[addr+k]  = flip[(addr+k) % 4];
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    v   = v | (32'(mem_m[addr+k]) << (8*k));
                    bad = bad | pbad[addr+k];
                end
                if (sgn && n < 4 && v[8*n-1]) begin
                    v = v | (32'hFFFF_FFFF << (8*n));
                end
            end
        end
        q.push_back('{rdata: v, err: err | bad, due: cyc + 1});
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called at the negedge where reset drops; holds a load request
    // while the sweep runs and counts cycles with req_ready low.
    task automatic sweep_count(output int cnt);
        cnt        = 0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_addr   = '0;
        while (!req_ready && cnt < 4 * DEPTH) begin
            if (!clr_busy) begin
                check("clr_busy", 33'(clr_busy), 33'h1);
            end
            cnt++;
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {30'h0, rsp_valid, req_ready, clr_busy},
              33'h1);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int a;
        logic [1:0] sz;
        logic [3:0] fl;

        model_clear();
        do_reset();
        sweep_count(cnt);
        check("sweep_len", 33'(cnt), 33'(DEPTH));
        check("run_busy", 33'(clr_busy), 33'h0);

        issue(0, 0, 2'd2, 0, 0);
        issue(0, 4*(DEPTH-1), 2'd2, 0, 0);

        issue(1, 'h10, 2'd2, 0, 32'h1122_3344);
        for (int i = 0; i < 4; i++) issue(0, 'h10 + i, 2'd0, 0, 0);

        issue(1, 'h21, 2'd0, 0, 32'h0000_0080);
        issue(0, 'h21, 2'd0, 1, 0);
        issue(0, 'h21, 2'd0, 0, 0);
        issue(0, 'h20, 2'd2, 0, 0);

        issue(1, 'h32, 2'd1, 0, 32'h0000_BEEF);
        issue(0, 'h32, 2'd1, 1, 0);
        issue(1, 'h33, 2'd1, 0, 32'h0000_1234);
        issue(0, 'h30, 2'd2, 0, 0);

        issue(1, 0, 2'd2, 0, 32'hCAFE_F00D);
        issue(0, NB, 2'd2, 0, 0);
        issue(0, 'h40, 2'd3, 0, 0);
        issue(0, 'h06, 2'd2, 0, 0);
        issue(1, NB, 2'd2, 0, 32'hDEAD_BEEF);
        issue(0, 0, 2'd2, 0, 0);
        idle();

`ifdef DM_PARITY_EN
        issue(1, 'h40, 2'd2, 0, 32'hA5A5_0F0F, 4'b0001);
        issue(0, 'h40, 2'd2, 0, 0);
        issue(0, 'h41, 2'd0, 0, 0);
        idle();
`endif

        for (int i = 0; i < 400; i++) begin
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 63);
            else a = $urandom_range(0, NB + 15);
            if ($urandom_range(0, 9) < 7 && sz != 2'd3) begin
                a = a & ~((1 << sz) - 1);
            end
            fl = 4'b0000;
`ifdef DM_PARITY_EN
            if ($urandom_range(0, 7) == 0) fl = 4'($urandom);
`endif
            issue($urandom_range(0, 1) == 1, a, sz,
                  $urandom_range(0, 1) == 1, $urandom, fl);
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();

        issue(1, 'h10, 2'd2, 0, 32'h5555_AAAA);
        idle();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        sweep_count(cnt);
        check("sweep_restart", 33'(cnt), 33'(DEPTH));
        issue(0, 'h10, 2'd2, 0, 0);
        issue(0, 'h20, 2'd2, 0, 0);

        repeat (3) idle();
        check("drain", 33'(q.size()), 33'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
